// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / sequencing controller.
// Holds the controller state encoding and the default PC and LUT index widths.
// Imported by pc_ctrl and target_lut.
package pc_pkg;

  // Default PC / instruction address width.
  localparam int PC_PW = 10;
  // Default target LUT index width (LUT depth is 2**PC_LW).
  localparam int PC_LW = 5;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } pc_state_t;

endpackage

// File: rtl/pc_ctrl_target_lut.sv
// Programmable jump/branch target table: 2**LW entries of PW bits.
// Ports: clk/rst (async active-high clear of every entry), we/waddr/wdata
//   synchronous write, raddr/rdata combinational read of pre-edge contents.
module target_lut
  import pc_pkg::*;
#(
  parameter int PW = PC_PW,
  parameter int LW = PC_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [LW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic [LW-1:0] raddr,
  output logic [PW-1:0] rdata
);

  localparam int DEPTH = 1 << LW;

  logic [PW-1:0] mem [DEPTH];

  // Reset clears every entry so a jump after reset always lands at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees the contents before this edge's write, so a same-cycle
  // write and jump to one index resolves to the old target.
  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter and sequencing controller downstream of the register file.
// Ports: Clk/Reset (async active-high); start/Ack handshake; Done_flag and
//   Zero_flag from the register file; Jump/Branch/TargetIdx/Stall decode;
//   LutWe/LutAddr/LutData target table writes; PC/FetchEn/Wrap outputs.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int PW = PC_PW,
  parameter int LW = PC_LW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          Done_flag,
  input  logic          Zero_flag,
  input  logic          Jump,
  input  logic          Branch,
  input  logic [LW-1:0] TargetIdx,
  input  logic          Stall,
  input  logic          LutWe,
  input  logic [LW-1:0] LutAddr,
  input  logic [PW-1:0] LutData,
  output logic [PW-1:0] PC,
  output logic          FetchEn,
  output logic          Ack,
  output logic          Wrap
);

  pc_state_t     state, state_nxt;
  logic [PW-1:0] pc_nxt;
  logic          ack_nxt;
  logic          wrap_nxt;
  logic [PW-1:0] target;

  target_lut #(
    .PW(PW),
    .LW(LW)
  ) u_target_lut (
    .clk   (Clk),
    .rst   (Reset),
    .we    (LutWe),
    .waddr (LutAddr),
    .wdata (LutData),
    .raddr (TargetIdx),
    .rdata (target)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      PC    <= '0;
      Ack   <= 1'b0;
      Wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      PC    <= pc_nxt;
      Ack   <= ack_nxt;
      Wrap  <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    ack_nxt   = Ack;
    wrap_nxt  = Wrap;

    case (state)
      IDLE: begin
        pc_nxt = '0;
        if (start) begin
          state_nxt = ARM;
          ack_nxt   = 1'b0;
          wrap_nxt  = 1'b0;
        end
      end

      // Held here for as long as start stays high; the run begins on the
      // edge after start falls, with PC still at 0.
      ARM: begin
        pc_nxt   = '0;
        ack_nxt  = 1'b0;
        wrap_nxt = 1'b0;
        if (!start) begin
          state_nxt = RUN;
        end
      end

      // Done outranks everything else; start is ignored while running.
      RUN: begin
        if (Done_flag) begin
          state_nxt = HALT;
          ack_nxt   = 1'b1;
        end else if (Stall) begin
          pc_nxt = PC;
        end else if (Jump || (Branch && Zero_flag)) begin
          pc_nxt = target;
        end else begin
          pc_nxt = PC + PW'(1);
          // Only sequential increment past all-ones marks a wrap.
          if (&PC) begin
            wrap_nxt = 1'b1;
          end
        end
      end

      HALT: begin
        if (start) begin
          state_nxt = ARM;
          pc_nxt    = '0;
          ack_nxt   = 1'b0;
          wrap_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
        ack_nxt   = 1'b0;
        wrap_nxt  = 1'b0;
      end
    endcase
  end

  assign FetchEn = (state == RUN);

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Program-counter and sequencing controller that sits directly downstream of the register file.
- Consumes the register file's Zero and Done flag outputs plus decoded control bits, and produces the instruction fetch address.
- Resolves branch and jump targets through a small programmable target lookup table (LUT).
- Runs the start/run/halt handshake with the testbench; ack reports completion.

Parameters:
- PW, 10, PC / instruction address width.
- LW, 5, LUT index width; the LUT holds 2**LW entries of PW bits.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  start request from testbench.
- Done_flag  input  1  Done flag from register file (Done_out).
- Zero_flag  input  1  Zero flag from register file (Zero_out).
- Jump  input  1  unconditional jump, decoded this cycle.
- Branch  input  1  branch if Zero_flag = 1, decoded this cycle.
- TargetIdx  input  LW  LUT index for Jump/Branch.
- Stall  input  1  hold PC this cycle.
- LutWe  input  1  LUT write enable.
- LutAddr  input  LW  LUT write index.
- LutData  input  PW  LUT write data.
- PC  output  PW  current fetch address.
- FetchEn  output  1  PC is valid for fetch this cycle.
- Ack  output  1  program finished (halted after a run).
- Wrap  output  1  sticky flag: PC wrapped past all-ones during the run.

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately, including mid-run. Reset values:
  - State = IDLE, PC = 0, FetchEn = 0, Ack = 0, Wrap = 0.
  - All LUT entries = 0.
- States: IDLE, ARM, RUN, HALT. All outputs are registered except FetchEn, which is decoded from state.
- IDLE:
  - PC = 0.
  - start = 1 -> ARM.
- ARM:
  - PC forced to 0, Wrap cleared, Ack = 0.
  - Stays in ARM while start = 1; start = 0 -> RUN on the next edge.
- RUN:
  - FetchEn = 1.
  - Per-edge priority, highest first:
    - Done_flag = 1 -> HALT; PC holds; Ack = 1 from the next cycle.
    - Stall = 1 -> PC holds.
    - Jump = 1 -> PC = LUT[TargetIdx].
    - Branch = 1 and Zero_flag = 1 -> PC = LUT[TargetIdx].
    - Branch = 1 and Zero_flag = 0 -> PC + 1.
    - Otherwise -> PC + 1.
  - Done beats Stall, Jump and Branch in the same cycle.
  - Jump and Branch together: Jump wins, so Branch is irrelevant.
- PC increment is modulo 2**PW.
  - All-ones + 1 -> 0, and Wrap is set and held until the next ARM.
  - Jump/branch targets never set Wrap.
- HALT:
  - FetchEn = 0, Ack = 1, PC holds its last value.
  - start = 1 -> ARM (Ack drops in ARM).
- Done_flag is ignored in IDLE, ARM and HALT. The register file reports Done = 1 out of reset and while not started.
- LUT:
  - Written on posedge when LutWe = 1, in any state.
  - Read is combinational from pre-edge contents. A same-cycle write and jump to the same index uses the OLD entry.
- start asserted during RUN is ignored; only Done or Reset exit RUN.

Decomposition:
- Shared package pc_pkg holds:
  - state enum pc_state_t {IDLE, ARM, RUN, HALT}, 2-bit;
  - PW/LW defaults as localparams.
- One natural sub-module: target_lut. It holds the 2**LW x PW storage, the synchronous write, the combinational read, and async clear on Reset.
- The FSM and PC datapath stay in pc_ctrl.

Test Plan:
1. Reset, then start high for 3 cycles, then low -> PC stays 0 through ARM. RUN begins and PC counts 0, 1, 2, 3 on successive edges with FetchEn = 1.
2. In RUN with PC = 5: write LUT[3] = 0x120 earlier, then Jump = 1 with TargetIdx = 3 -> PC = 0x120 next cycle. Branch with Zero_flag = 0 at idx 3 -> PC = 0x121. Branch with Zero_flag = 1 -> PC = 0x120.
3. Done_flag = 1 together with Jump = 1 and Stall = 1 at PC = 0x40 -> HALT, PC stays 0x40, Ack = 1, FetchEn = 0. A later start pulse -> ARM, Ack = 0, PC = 0.
4. LUT[7] = 0x3FF, Jump to idx 7, then two free-running cycles -> PC goes 0x3FF, 0x000, 0x001 and Wrap = 1. Wrap stays 1 through HALT and clears in ARM.
5. Same-cycle LutWe to idx 2 (0x055 over old 0x011) and Jump idx 2 -> PC = 0x011. The next jump to idx 2 -> PC = 0x055.
6. Assert Reset asynchronously mid-RUN at PC = 0x0A7, between clock edges -> PC = 0, state IDLE, Ack = 0, Wrap = 0 immediately. A jump to any index after restart lands at 0 because the LUT was cleared.
